mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 68 ++++++
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if -- signal bundle between the EXE/MEM pipeline latch, the data RAM,
// the WB stage and the MEM stage of the five-stage pipeline.
//
// Signals:
//   MEM_valid      MEM stage holds a valid instruction (held until retire)
//   EXE_MEM_bus_r  155-bit latched EXE->MEM bus
//   WB_allow_in    WB stage can accept an instruction
//   dm_rdata       data RAM read word, valid one cycle after dm_addr
//   dm_addr        data RAM word address
//   dm_wen         data RAM byte write enables
//   dm_wdata       data RAM write data
//   MEM_over       MEM stage instruction complete, result valid
//   MEM_WB_bus     120-bit MEM->WB bus
//   MEM_wdest      destination register (0 when MEM stage is empty)
//   MEM_rf_wen     register-file write enable of the held instruction
//   MEM_fwd_data   bypass value, meaningful while MEM_over is high
//   MEM_pc         pc of the held instruction
//
// Modports:
//   master  pipeline/environment side (drives valid, bus, allow-in and RAM read data)
//   slave   the MEM stage itself
interface mem_stage_if;
  logic         MEM_valid;
  logic [154:0] EXE_MEM_bus_r;
  logic         WB_allow_in;
  logic [31:0]  dm_rdata;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic         MEM_over;
  logic [119:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic         MEM_rf_wen;
  logic [31:0]  MEM_fwd_data;
  logic [31:0]  MEM_pc;

  modport master (
    output MEM_valid,
    output EXE_MEM_bus_r,
    output WB_allow_in,
    output dm_rdata,
    input  dm_addr,
    input  dm_wen,
    input  dm_wdata,
    input  MEM_over,
    input  MEM_WB_bus,
    input  MEM_wdest,
    input  MEM_rf_wen,
    input  MEM_fwd_data,
    input  MEM_pc
  );

  modport slave (
    input  MEM_valid,
    input  EXE_MEM_bus_r,
    input  WB_allow_in,
    input  dm_rdata,
    output dm_addr,
    output dm_wen,
    output dm_wdata,
    output MEM_over,
    output MEM_WB_bus,
    output MEM_wdest,
    output MEM_rf_wen,
    output MEM_fwd_data,
    output MEM_pc
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: issues data RAM loads/stores for the held
// instruction, formats load data and forwards the result to WB.
//
// Ports:
//   clk     pipeline clock, all state changes on the rising edge
//   reset   synchronous active-high reset
//   mem_if  mem_stage_if.slave bundle (valid/bus/allow-in in, RAM port and WB bus out)
//
// Timing: non-load instructions complete in the first MEM cycle; loads present
// the address in the first cycle, capture the RAM word one cycle later and
// complete in the third state (DONE). Stores write only in the first cycle.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned word accesses
// (addr_err); flagged stores do not write and flagged loads complete at once
// with mem_result = exe_result. Without it, low address bits are ignored for
// word accesses and addr_err is always 0.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  mem_if
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLdWait = 2'd1,
    StDone   = 2'd2
  } state_e;

  // EXE->MEM bus fields, MSB first
  logic        load;
  logic        store;
  logic        ls_word;
  logic        lb_sign;
  logic [31:0] store_data;
  logic [31:0] exe_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;
  logic        mfhi;
  logic        mflo;
  logic        mtc0;
  logic        mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall;
  logic        eret;
  logic        rf_wen;
  logic [4:0]  rf_wdest;
  logic        overflow;
  logic [31:0] pc;

  assign {load, store, ls_word, lb_sign, store_data, exe_result, lo_result,
          hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret,
          rf_wen, rf_wdest, overflow, pc} = mem_if.EXE_MEM_bus_r;

  logic addr_err;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = (load | store) & ls_word & (exe_result[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        store_done_q, store_done_d;
  logic [31:0] load_data_q, load_data_d;

  logic        load_go;     // load that really goes to the RAM
  logic        store_fire;  // store write issued this cycle
  logic        mem_over;
  logic        retire;
  logic [7:0]  ld_byte;
  logic [31:0] load_fmt;
  logic [31:0] mem_result;

  assign load_go = load & ~addr_err;

  // Byte lane selection for byte loads (little-endian lanes)
  always_comb begin
    ld_byte = 8'h00;
    unique case (exe_result[1:0])
      2'd0: ld_byte = mem_if.dm_rdata[7:0];
      2'd1: ld_byte = mem_if.dm_rdata[15:8];
      2'd2: ld_byte = mem_if.dm_rdata[23:16];
      2'd3: ld_byte = mem_if.dm_rdata[31:24];
    endcase
  end

  assign load_fmt = ls_word ? mem_if.dm_rdata
                            : {{24{lb_sign & ld_byte[7]}}, ld_byte};

  // Completion; forced low during reset regardless of MEM_valid
  always_comb begin
    mem_over = 1'b0;
    if (!reset && mem_if.MEM_valid) begin
      case (state_q)
        StIdle:   mem_over = ~load_go;
        StLdWait: mem_over = 1'b0;
        StDone:   mem_over = 1'b1;
        default:  mem_over = 1'b0;
      endcase
    end
  end

  assign retire = mem_over & mem_if.WB_allow_in;

  // store_done guards against a repeat write while the store stalls in DONE
  assign store_fire = ~reset & mem_if.MEM_valid & (state_q == StIdle) & store &
                      ~addr_err & ~store_done_q;

  always_comb begin
    state_d      = state_q;
    store_done_d = store_done_q;
    load_data_d  = load_data_q;
    case (state_q)
      StIdle: begin
        if (mem_if.MEM_valid) begin
          if (load_go) begin
            state_d = StLdWait;
          end else if (!retire) begin
            // Completed but WB not ready: hold in DONE
            state_d = StDone;
            if (store_fire) store_done_d = 1'b1;
          end
          // Retire straight from IDLE keeps us in IDLE so a following
          // instruction is accepted with no bubble
        end
      end
      StLdWait: begin
        if (!mem_if.MEM_valid) begin
          state_d = StIdle;
        end else begin
          load_data_d = load_fmt;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (!mem_if.MEM_valid || retire) begin
          state_d      = StIdle;
          store_done_d = 1'b0;
        end
      end
      default: begin
        state_d      = StIdle;
        store_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      store_done_q <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      store_done_q <= store_done_d;
      load_data_q  <= load_data_d;
    end
  end

  assign mem_result = load_go ? load_data_q : exe_result;

  // Data RAM port
  assign mem_if.dm_addr  = {exe_result[31:2], 2'b00};
  assign mem_if.dm_wen   = !store_fire ? 4'b0000 :
                           ls_word     ? 4'b1111 : (4'b0001 << exe_result[1:0]);
  assign mem_if.dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

  // WB side
  assign mem_if.MEM_over     = mem_over;
  assign mem_if.MEM_WB_bus   = {mem_result, lo_result, hi_write, lo_write, mfhi, mflo,
                                mtc0, mfc0, cp0r_addr, syscall, eret, rf_wen, rf_wdest,
                                overflow, addr_err, pc};
  assign mem_if.MEM_wdest    = mem_if.MEM_valid ? rf_wdest : 5'd0;
  assign mem_if.MEM_rf_wen   = rf_wen & mem_if.MEM_valid;
  assign mem_if.MEM_fwd_data = mem_result;
  assign mem_if.MEM_pc       = pc;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage.
// A small read-only RAM model returns dm_rdata one cycle after dm_addr; a write
// counter tallies cycles with nonzero dm_wen.
module tb_mem_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   wr_count;
  logic [31:0] ram [0:255];

  mem_stage_if mem_if ();

  mem_stage u_dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_if.dm_rdata <= ram[mem_if.dm_addr[9:2]];
    if (mem_if.dm_wen != 4'h0) wr_count <= wr_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [154:0] make_bus(input logic ld, input logic st, input logic word,
                                            input logic sgn, input logic [31:0] sdata,
                                            input logic [31:0] exe, input logic [31:0] pcv);
    logic [31:0] lo;
    lo = 32'hCAFE0001;
    return {ld, st, word, sgn, sdata, exe, lo, 6'b101010, 8'h5A, 1'b0, 1'b1, 1'b1,
            5'd9, 1'b0, pcv};
  endfunction

  // Expected WB bus built from the bench's own field values
  function automatic logic [119:0] make_wb(input logic [31:0] res, input logic aerr,
                                           input logic [31:0] pcv);
    logic [31:0] lo;
    lo = 32'hCAFE0001;
    return {res, lo, 6'b101010, 8'h5A, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, aerr, pcv};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [154:0] b);
    mem_if.EXE_MEM_bus_r = b;
    mem_if.MEM_valid     = 1'b1;
  endtask

  task automatic idle();
    mem_if.MEM_valid     = 1'b0;
    mem_if.EXE_MEM_bus_r = '0;
  endtask

  // Load: MEM_over low in cycles 0 and 1, high with data in cycle 2
  task automatic run_load(input logic [154:0] b, input logic [31:0] exp, input string tag);
    present(b);
    mem_if.WB_allow_in = 1'b1;
    #1;
    check({tag, "_c0_over"}, 120'(mem_if.MEM_over), 120'(0));
    cyc();
    check({tag, "_c1_over"}, 120'(mem_if.MEM_over), 120'(0));
    cyc();
    check({tag, "_c2_over"}, 120'(mem_if.MEM_over), 120'(1));
    check({tag, "_data"}, 120'(mem_if.MEM_fwd_data), 120'(exp));
    cyc();
    idle();
    #1;
  endtask

  logic [154:0] b;
  int w0;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h40] = 32'h80123456;
    ram[8'h80] = 32'h0000C300;
    ram[8'h81] = 32'h12345678;
    reset = 1'b1;
    mem_if.WB_allow_in = 1'b1;
    idle();
    repeat (2) cyc();

    // Reset with a valid store presented: nothing may happen
    b = make_bus(0, 1, 1, 0, 32'hDEADBEEF, 32'h100, 32'hBFC0_0010);
    present(b);
    #1;
    check("rst_wen", 120'(mem_if.dm_wen), 120'(0));
    check("rst_over", 120'(mem_if.MEM_over), 120'(0));
    cyc();

    // Word store 0x100 completes and writes in the same cycle
    reset = 1'b0;
    #1;
    check("sw_wen", 120'(mem_if.dm_wen), 120'(4'b1111));
    check("sw_wdata", 120'(mem_if.dm_wdata), 120'(32'hDEADBEEF));
    check("sw_addr", 120'(mem_if.dm_addr), 120'(32'h100));
    check("sw_over", 120'(mem_if.MEM_over), 120'(1));
    check("sw_wb", mem_if.MEM_WB_bus, make_wb(32'h100, 1'b0, 32'hBFC0_0010));
    check("sw_wdest", 120'(mem_if.MEM_wdest), 120'(9));
    check("sw_pc", 120'(mem_if.MEM_pc), 120'(32'hBFC0_0010));
    cyc();
    idle();
    #1;
    check("empty_over", 120'(mem_if.MEM_over), 120'(0));
    check("empty_wdest", 120'(mem_if.MEM_wdest), 120'(0));
    check("empty_rfwen", 120'(mem_if.MEM_rf_wen), 120'(0));
    cyc();

    // Signed byte load from 0x103 (byte 0x80)
    b = make_bus(1, 0, 0, 1, 32'h0, 32'h103, 32'hBFC0_0020);
    run_load(b, 32'hFFFFFF80, "lb");
    // Zero-extended byte load from 0x201 (byte 0xC3)
    b = make_bus(1, 0, 0, 0, 32'h0, 32'h201, 32'hBFC0_0024);
    run_load(b, 32'h000000C3, "lbu");

    // Word load held in DONE by WB for one cycle
    b = make_bus(1, 0, 1, 0, 32'h0, 32'h204, 32'hBFC0_0028);
    present(b);
    #1;
    cyc();
    mem_if.WB_allow_in = 1'b0;
    cyc();
    check("lw_over", 120'(mem_if.MEM_over), 120'(1));
    check("lw_wb", mem_if.MEM_WB_bus, make_wb(32'h12345678, 1'b0, 32'hBFC0_0028));
    cyc();
    check("lw_hold_over", 120'(mem_if.MEM_over), 120'(1));
    check("lw_hold_data", 120'(mem_if.MEM_fwd_data), 120'(32'h12345678));
    mem_if.WB_allow_in = 1'b1;
    cyc();
    idle();
    #1;

    // Byte store 0x102 stalled three cycles: exactly one write
    w0 = wr_count;
    b = make_bus(0, 1, 0, 0, 32'h000000AB, 32'h102, 32'hBFC0_0030);
    present(b);
    mem_if.WB_allow_in = 1'b0;
    #1;
    check("sb_wen", 120'(mem_if.dm_wen), 120'(4'b0100));
    check("sb_wdata", 120'(mem_if.dm_wdata), 120'(32'hABABABAB));
    check("sb_over", 120'(mem_if.MEM_over), 120'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("sb_stall_wen", 120'(mem_if.dm_wen), 120'(0));
      check("sb_stall_over", 120'(mem_if.MEM_over), 120'(1));
    end
    mem_if.WB_allow_in = 1'b1;
    cyc();
    idle();
    #1;
    check("sb_writes", 120'(wr_count - w0), 120'(1));

    // Back-to-back: ALU op retires in IDLE, store follows with no bubble
    b = make_bus(0, 0, 0, 0, 32'h0, 32'h55, 32'hBFC0_0040);
    present(b);
    #1;
    check("alu_over", 120'(mem_if.MEM_over), 120'(1));
    check("alu_fwd", 120'(mem_if.MEM_fwd_data), 120'(32'h55));
    cyc();
    b = make_bus(0, 1, 1, 0, 32'h11, 32'h300, 32'hBFC0_0044);
    present(b);
    #1;
    check("b2b_over", 120'(mem_if.MEM_over), 120'(1));
    check("b2b_wen", 120'(mem_if.dm_wen), 120'(4'b1111));
    cyc();
    idle();
    #1;

    // Flush in LD_WAIT, then a fresh load must start from IDLE
    b = make_bus(1, 0, 1, 0, 32'h0, 32'h204, 32'hBFC0_0050);
    present(b);
    #1;
    cyc();
    idle();
    #1;
    check("flush_ld_over", 120'(mem_if.MEM_over), 120'(0));
    cyc();
    run_load(b, 32'h12345678, "reload");

    // Flush of a stalled store in DONE; re-presented store writes again
    b = make_bus(0, 1, 0, 0, 32'h000000AB, 32'h102, 32'hBFC0_0060);
    present(b);
    mem_if.WB_allow_in = 1'b0;
    #1;
    cyc();
    idle();
    #1;
    cyc();
    present(b);
    #1;
    check("flush_st_wen", 120'(mem_if.dm_wen), 120'(4'b0100));
    mem_if.WB_allow_in = 1'b1;
    cyc();
    idle();
    #1;

    // Reset in LD_WAIT discards the read
    b = make_bus(1, 0, 0, 1, 32'h0, 32'h103, 32'hBFC0_0070);
    present(b);
    #1;
    cyc();
    reset = 1'b1;
    #1;
    check("rst_ld_over", 120'(mem_if.MEM_over), 120'(0));
    check("rst_ld_wen", 120'(mem_if.dm_wen), 120'(0));
    cyc();
    reset = 1'b0;
    run_load(b, 32'hFFFFFF80, "post_rst");

    // Misaligned word store at 0x101
    b = make_bus(0, 1, 1, 0, 32'h01020304, 32'h101, 32'hBFC0_0080);
    present(b);
    #1;
    check("mis_over", 120'(mem_if.MEM_over), 120'(1));
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_wen", 120'(mem_if.dm_wen), 120'(0));
    check("mis_aerr", 120'(mem_if.MEM_WB_bus[32]), 120'(1));
`else
    check("mis_wen", 120'(mem_if.dm_wen), 120'(4'b1111));
    check("mis_addr", 120'(mem_if.dm_addr), 120'(32'h100));
    check("mis_aerr", 120'(mem_if.MEM_WB_bus[32]), 120'(0));
`endif
    cyc();
    idle();
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
